arm7tdmi_fetch_buffer: RTL and testbench
========================================

Name: arm7tdmi_fetch_buffer

Overview:
- Fetch stage that produces the instruction stream consumed by arm7tdmi_decode (instruction, pc_in, instr_valid, stall, flush, thumb_mode).
- Issues sequential word or halfword requests to the instruction memory port and holds returned instructions in a small prefetch FIFO.
- Presents the FIFO head to decode and redirects to a branch target on flush.
- Sits between the imem interface and decode in the core pipeline.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of two, 2..8).
- RESET_VECTOR, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  request valid; held with imem_addr until imem_ack
- imem_addr  output  32  fetch address (word-aligned ARM, halfword-aligned Thumb)
- imem_ack  input  1  data valid on imem_rdata, accepted same cycle
- imem_rdata  input  32  aligned word containing the requested address
- thumb_mode  input  1  instruction set for fetches after the next flush/reset
- flush  input  1  redirect: discard queue, restart at branch_target
- branch_target  input  32  new fetch address, sampled when flush=1
- stall  input  1  decode not accepting; head held
- instruction  output  32  FIFO head; Thumb = {16'h0, halfword}
- pc_out  output  32  address of the head instruction
- instr_valid  output  1  FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_VECTOR, FIFO empty, imem_req=0, imem_addr=0, instruction=0, pc_out=0, instr_valid=0, state=IDLE, latched mode=ARM.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, result kept.
  - DISCARD: request outstanding, result dropped.
- IDLE -> WAIT: when count + 0 < DEPTH and flush=0. imem_req=1 and imem_addr=fetch_pc are registered, so the request is visible on the next edge.
- First request asserts on the first clk edge after rst_n rises.
- Only one request is outstanding at a time. imem_addr and imem_req are stable while waiting.
- WAIT with imem_ack=1:
  - Push {fetch_pc, data} into the FIFO.
  - fetch_pc += 4 (ARM) or += 2 (Thumb).
  - imem_req drops for at least one cycle, then the block returns to IDLE.
  - Thumb data = imem_rdata[31:16] if fetch_pc[1], else [15:0].
- Never issue a request unless a FIFO slot is reserved: count < DEPTH at issue time, with a pop-then-push guarantee.
- Pop: instr_valid && !stall. Push and pop in the same cycle are allowed, including when full (count unchanged).
- Full: no new request until a pop. Empty: instr_valid=0 and instruction/pc_out hold their last values.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH)+1.
- Flush (any state):
  - FIFO cleared the next cycle.
  - instr_valid=0 the next cycle.
  - fetch_pc = branch_target & ~1 (Thumb) or & ~3 (ARM).
  - Latched mode = thumb_mode.
- Flush in WAIT without ack: go to DISCARD. imem_req stays asserted until ack, and that ack's data is dropped. Then go to IDLE and fetch from the target.
- Flush in the same cycle as imem_ack: the ack completes the old request, its data is dropped, and the next state is IDLE with the new target.
- Flush during DISCARD: update target only, stay in DISCARD.
- Flush wins over a same-cycle pop/push.
- A thumb_mode change without flush has no effect.
- Reset mid-request: all state cleared. A late imem_ack arriving in IDLE after reset is ignored.

Optional Feature:
- Macro ARM7TDMI_FETCH_STATS_EN.
- When defined, adds outputs stat_fetched[31:0] (incremented on each kept push) and stat_discarded[31:0] (incremented on each ack dropped in DISCARD or on flush+ack). Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, imem_ack one cycle after each req, rdata=addr^32'hE0000000, stall=0 -> imem_addr 0,4,8,C; pc_out 0,4,8 with matching instruction; no gaps beyond the ack latency.
- stall=1 held 10 cycles, DEPTH=2 -> exactly 2 entries accepted, imem_req stays 0 afterward, head pc_out=0 stable. Release stall -> pops 0 then 4, fetching resumes at 8.
- Flush with branch_target=32'h101, thumb_mode=1, rdata=32'hBEEF_0148:
  - next request imem_addr=32'h100 gives instruction 32'h00000148, pc_out 32'h100;
  - next request 32'h102 gives 32'h0000BEEF.
- Flush while WAIT with ack delayed 3 cycles -> imem_req held at the old address until ack, that data never appears on instr_valid, next imem_addr=target.
- Flush and imem_ack in the same cycle -> acked data dropped, the next request goes to the target, and stat_discarded increments by 1 with the macro defined.
- Assert rst_n=0 mid-WAIT, then ack after release -> stray ack ignored, first request at RESET_VECTOR, instr_valid=0 until its ack.

Source files
------------

// File: rtl/arm7tdmi_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master) and imem (slave).
interface arm7tdmi_fetch_buffer_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/arm7tdmi_fetch_buffer.sv
// Fetch stage: one outstanding imem request at a time feeding a DEPTH-entry prefetch FIFO for decode.
// ARM7TDMI_FETCH_STATS_EN adds stat_fetched / stat_discarded ack counters.
module arm7tdmi_fetch_buffer #(
   parameter int unsigned DEPTH        = 2,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   arm7tdmi_fetch_buffer_if.master        imem,
   input  logic                           thumb_mode,
   input  logic                           flush,
   input  logic [31:0]                    branch_target,
   input  logic                           stall,
   output logic [31:0]                    instruction,
   output logic [31:0]                    pc_out,
   output logic                           instr_valid
`ifdef ARM7TDMI_FETCH_STATS_EN
   ,
   output logic [31:0]                    stat_fetched,
   output logic [31:0]                    stat_discarded
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             req_nxt;
   logic [31:0]      addr_nxt;

   logic [31:0]      fetch_pc;
   logic [31:0]      fetch_pc_nxt;
   logic [31:0]      pc_step;
   logic             mode_thumb;

   logic             keep_ack;
   logic             push;
   logic             pop;
   logic [31:0]      push_dat;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      fifo_pc  [DEPTH];
   logic [31:0]      fifo_dat [DEPTH];
   logic [31:0]      hold_pc;
   logic [31:0]      hold_dat;

   // An ack in WAIT is kept only if no flush lands in the same cycle.
   assign keep_ack = imem.ack && (state == WAIT) && !flush;
   assign push     = keep_ack;
   assign pop      = instr_valid && !stall && !flush;

   assign pc_step  = mode_thumb ? 32'd2 : 32'd4;
   assign push_dat = mode_thumb
                   ? {16'h0000, (fetch_pc[1] ? imem.rdata[31:16] : imem.rdata[15:0])}
                   : imem.rdata;

   always_comb begin
      fetch_pc_nxt = fetch_pc;
      if (flush) begin
         fetch_pc_nxt = branch_target & (thumb_mode ? ~32'h1 : ~32'h3);
      end else if (keep_ack) begin
         fetch_pc_nxt = fetch_pc + pc_step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = imem.req;
      addr_nxt  = imem.addr;
      case (state)
         IDLE: begin
            if (!flush && (count < DEPTH_C)) begin
               state_nxt = WAIT;
               req_nxt   = 1'b1;
               addr_nxt  = fetch_pc;
            end
         end
         WAIT: begin
            if (imem.ack) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
            end else if (flush) begin
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            if (imem.ack) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem.req   <= 1'b0;
         imem.addr  <= 32'h0000_0000;
         fetch_pc   <= RESET_VECTOR;
         mode_thumb <= 1'b0;
      end else begin
         imem.req  <= req_nxt;
         imem.addr <= addr_nxt;
         fetch_pc  <= fetch_pc_nxt;
         if (flush) begin
            mode_thumb <= thumb_mode;
         end
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]  <= fetch_pc;
         fifo_dat[wr_ptr] <= push_dat;
      end
   end

   // Remember the last presented head so the outputs hold while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_pc  <= 32'h0000_0000;
         hold_dat <= 32'h0000_0000;
      end else if (instr_valid) begin
         hold_pc  <= fifo_pc[rd_ptr];
         hold_dat <= fifo_dat[rd_ptr];
      end
   end

   assign instr_valid = (count != '0);
   assign instruction = instr_valid ? fifo_dat[rd_ptr] : hold_dat;
   assign pc_out      = instr_valid ? fifo_pc[rd_ptr]  : hold_pc;

`ifdef ARM7TDMI_FETCH_STATS_EN
   logic drop_ack;
   assign drop_ack = imem.ack && ((state == DISCARD) || ((state == WAIT) && flush));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched   <= 32'h0000_0000;
         stat_discarded <= 32'h0000_0000;
      end else begin
         if (keep_ack) begin
            stat_fetched <= stat_fetched + 32'd1;
         end
         if (drop_ack) begin
            stat_discarded <= stat_discarded + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_arm7tdmi_fetch_buffer.sv
// Scoreboard bench: the imem model pushes expected {pc, instruction} on each kept ack, decode-side pops compare.
module tb_arm7tdmi_fetch_buffer;
   localparam int unsigned DEPTH        = 2;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        thumb_mode;
   logic        flush;
   logic [31:0] branch_target;
   logic        stall;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        instr_valid;
`ifdef ARM7TDMI_FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_discarded;
`endif

   always #5 clk = ~clk;

   arm7tdmi_fetch_buffer_if imem_bus();

   arm7tdmi_fetch_buffer #(.DEPTH(DEPTH), .RESET_VECTOR(RESET_VECTOR)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (imem_bus),
      .thumb_mode    (thumb_mode),
      .flush         (flush),
      .branch_target (branch_target),
      .stall         (stall),
      .instruction   (instruction),
      .pc_out        (pc_out),
      .instr_valid   (instr_valid)
`ifdef ARM7TDMI_FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_discarded (stat_discarded)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] req_addr_log[$];
   int          req_cyc_log[$];

   int vectors     = 0;
   int miscompares = 0;

   // Memory-model controls, written by the main sequence only.
   int          mem_lat        = 0;
   bit          ack_with_flush = 1'b0;
   bit          fixed_en       = 1'b0;
   logic [31:0] fixed_rdata    = 32'h0;
   int          stray_req      = 0;

   // Memory-model state, written by the monitor only.
   int          cyc        = 0;
   int          acks       = 0;
   int          stray_done = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // imem responder, reference model and decode-side scoreboard, all sampled on the falling edge.
   initial begin : monitor
      bit          outstanding = 1'b0;
      bit          drop        = 1'b0;
      bit          ack_real    = 1'b0;
      bit          just_real;
      bit          flush_q     = 1'b0;
      bit          exp_mode    = 1'b0;
      int          cnt         = 0;
      logic [31:0] cur_addr    = 32'h0;
      logic [31:0] exp_pc      = RESET_VECTOR;
      logic [31:0] rd;
      exp_t        e;
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            imem_bus.ack = 1'b0;
            outstanding  = 1'b0;
            drop         = 1'b0;
            flush_q      = 1'b0;
            exp_mode     = 1'b0;
            exp_pc       = RESET_VECTOR;
            sb.delete();
         end else begin
            just_real = 1'b0;
            if (flush_q) check("flush_clears_valid", instr_valid, 1'b0);
            if (instr_valid && !stall && !flush) begin
               if (sb.size() == 0) begin
                  check("spurious_valid", instr_valid, 1'b0);
               end else begin
                  e = sb.pop_front();
                  check("head_pc", pc_out, e.pc);
                  check("head_instr", instruction, e.dat);
               end
            end
            if (imem_bus.ack) begin
               imem_bus.ack = 1'b0;
               if (ack_real) begin
                  check("req_drop_after_ack", imem_bus.req, 1'b0);
                  outstanding = 1'b0;
                  just_real   = 1'b1;
               end
            end else if (outstanding) begin
               check("req_hold", {imem_bus.req, imem_bus.addr}, {1'b1, cur_addr});
            end
            if (!outstanding && imem_bus.req && !just_real) begin
               check("req_addr", imem_bus.addr, exp_pc);
               outstanding = 1'b1;
               cur_addr    = imem_bus.addr;
               cnt         = mem_lat;
               req_addr_log.push_back(imem_bus.addr);
               req_cyc_log.push_back(cyc);
            end
            if (outstanding && !just_real) begin
               if (cnt == 0 || (ack_with_flush && flush)) begin
                  rd             = fixed_en ? fixed_rdata : (cur_addr ^ 32'hE000_0000);
                  imem_bus.ack   = 1'b1;
                  imem_bus.rdata = rd;
                  ack_real       = 1'b1;
                  acks++;
                  if (!drop && !flush) begin
                     e.pc  = exp_pc;
                     e.dat = exp_mode ? {16'h0, (exp_pc[1] ? rd[31:16] : rd[15:0])} : rd;
                     sb.push_back(e);
                     exp_pc = exp_pc + (exp_mode ? 32'd2 : 32'd4);
                  end
                  drop = 1'b0;
               end else begin
                  cnt--;
               end
            end
            if (stray_req != stray_done && !outstanding) begin
               stray_done++;
               imem_bus.ack   = 1'b1;
               imem_bus.rdata = 32'hDEAD_BEEF;
               ack_real       = 1'b0;
            end
            if (flush) begin
               if (outstanding && !(imem_bus.ack && ack_real)) drop = 1'b1;
               sb.delete();
               exp_pc   = branch_target & (thumb_mode ? ~32'h1 : ~32'h3);
               exp_mode = thumb_mode;
            end
            flush_q = flush;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input bit stray);
      rst_n = 1'b0;
      #1;
      check("rst_req", imem_bus.req, 1'b0);
      check("rst_addr", imem_bus.addr, 32'h0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_instr", instruction, 32'h0);
      check("rst_pc", pc_out, 32'h0);
      tick(2);
      if (stray) stray_req++;
      rst_n = 1'b1;
   endtask

   task automatic wait_new_req(input int n0, input int budget);
      for (int i = 0; i < budget && req_addr_log.size() <= n0; i++) tick(1);
      if (req_addr_log.size() <= n0) check("req_timeout", req_addr_log.size(), n0 + 1);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !instr_valid; i++) tick(1);
      if (!instr_valid) check("valid_timeout", instr_valid, 1'b1);
   endtask

   initial begin : main
      int          base;
      logic [31:0] old_addr;
`ifdef ARM7TDMI_FETCH_STATS_EN
      logic [31:0] d0;
`endif
      rst_n         = 1'b0;
      stall         = 1'b0;
      flush         = 1'b0;
      thumb_mode    = 1'b0;
      branch_target = 32'h0;
      tick(1);

      // Streaming ARM fetch, single-cycle ack latency.
      do_reset(1'b0);
      base = req_addr_log.size();
      tick(1);
      check("first_req", imem_bus.req, 1'b1);
      tick(11);
      if (req_addr_log.size() < base + 4) begin
         check("stream_req_count", req_addr_log.size() - base, 4);
      end else begin
         for (int i = 0; i < 4; i++) check("stream_addr", req_addr_log[base + i], 32'(i * 4));
         for (int i = 0; i < 3; i++) check("stream_gap", req_cyc_log[base + i + 1] - req_cyc_log[base + i], 2);
      end

      // Decode stalled from reset: only DEPTH entries are fetched.
      stall = 1'b1;
      do_reset(1'b0);
      base = acks;
      tick(10);
      check("stall_accepts", acks - base, DEPTH);
      check("stall_req_idle", imem_bus.req, 1'b0);
      check("stall_head_valid", instr_valid, 1'b1);
      check("stall_head_pc", pc_out, RESET_VECTOR);
      base  = req_addr_log.size();
      stall = 1'b0;
      wait_new_req(base, 10);
      if (req_addr_log.size() > base) check("stall_resume_addr", req_addr_log[base], 32'h8);
      tick(4);

      // Thumb redirect; mode changes without flush are ignored afterwards.
      fixed_en      = 1'b1;
      fixed_rdata   = 32'hBEEF_0148;
      branch_target = 32'h101;
      thumb_mode    = 1'b1;
      flush         = 1'b1;
      tick(1);
      flush      = 1'b0;
      thumb_mode = 1'b0;
      check("flush_valid_low", instr_valid, 1'b0);
      wait_valid(20);
      check("thumb_lo_pc", pc_out, 32'h100);
      check("thumb_lo_instr", instruction, 32'h0000_0148);
      tick(1);
      wait_valid(20);
      check("thumb_hi_pc", pc_out, 32'h102);
      check("thumb_hi_instr", instruction, 32'h0000_BEEF);
      tick(3);

      // Flush while a slow request is outstanding.
      fixed_en = 1'b0;
      mem_lat  = 3;
      base     = req_addr_log.size();
      wait_new_req(base, 20);
      old_addr      = req_addr_log[req_addr_log.size() - 1];
      branch_target = 32'h203;
      flush         = 1'b1;
      tick(1);
      flush = 1'b0;
      check("discard_req_held", {imem_bus.req, imem_bus.addr}, {1'b1, old_addr});
      base = req_addr_log.size();
      wait_new_req(base, 20);
      if (req_addr_log.size() > base) check("discard_next_addr", req_addr_log[base], 32'h200);
      tick(8);

      // Flush coinciding with the ack.
      mem_lat        = 20;
      ack_with_flush = 1'b1;
      base           = req_addr_log.size();
      wait_new_req(base, 30);
`ifdef ARM7TDMI_FETCH_STATS_EN
      d0 = stat_discarded;
`endif
      branch_target = 32'h300;
      flush         = 1'b1;
      tick(1);
      flush          = 1'b0;
      ack_with_flush = 1'b0;
      mem_lat        = 0;
      check("flush_ack_req_low", imem_bus.req, 1'b0);
`ifdef ARM7TDMI_FETCH_STATS_EN
      check("stat_discarded_step", stat_discarded - d0, 32'd1);
`endif
      base = req_addr_log.size();
      wait_new_req(base, 10);
      if (req_addr_log.size() > base) check("flush_ack_next_addr", req_addr_log[base], 32'h300);
      tick(6);

      // Reset mid-request, then a stray ack after release.
      mem_lat = 6;
      base    = req_addr_log.size();
      wait_new_req(base, 20);
      mem_lat = 0;
      do_reset(1'b1);
      tick(1);
      check("post_rst_req", imem_bus.req, 1'b1);
      check("post_rst_addr", imem_bus.addr, RESET_VECTOR);
      check("post_rst_valid", instr_valid, 1'b0);
      wait_valid(10);
      check("post_rst_pc", pc_out, RESET_VECTOR);
      check("post_rst_instr", instruction, RESET_VECTOR ^ 32'hE000_0000);
      tick(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
